// File: rtl/bmp_sink_pkg.sv
// -----------------------------------------------------------------------------
// bmp_sink_pkg
// Shared definitions for the master-port sink:
//   - source tag encodings carried on mstr0_data_valid
//   - per-channel frame state
// -----------------------------------------------------------------------------
package bmp_sink_pkg;

  localparam logic [1:0] SRC_IDLE = 2'b00;
  localparam logic [1:0] SRC_SLV0 = 2'b01;
  localparam logic [1:0] SRC_SLV1 = 2'b10;
  localparam logic [1:0] SRC_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } chan_state_e;

endpackage : bmp_sink_pkg

// File: rtl/bmp_sink_chan.sv
// -----------------------------------------------------------------------------
// bmp_sink_chan
// One output channel of the master-port sink: a FIFO, the frame FSM, the
// per-frame word counter and (with SINK_CHECKSUM_EN) an XOR checksum.
//
// Optional feature macro: SINK_CHECKSUM_EN (adds frame_csum).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push           word accepted for this channel this cycle
//   push_data      accepted word
//   frame_end      end-of-frame seen for this channel this cycle
//   full           FIFO full
//   state          frame state (IDLE / RECV / DRAIN)
//   out_data       FIFO head
//   out_valid      FIFO not empty
//   out_ready      consumer accepts the head
//   frame_done     one-cycle pulse: frame complete and FIFO drained
//   frame_words    word count of the last completed frame
//   frame_csum     XOR of the last completed frame (SINK_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module bmp_sink_chan
  import bmp_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  frame_end,
  output logic                  full,
  output chan_state_e           state,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_words
`ifdef SINK_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] frame_csum
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty;
  logic                  pop;

  chan_state_e           state_next;
  logic                  frame_start;
  logic                  frame_finish;
  logic [CNT_WIDTH-1:0]  cnt;

  // ---------------------------------------------------------------------------
  // FIFO: the extra pointer MSB separates full (MSBs differ) from empty.
  // ---------------------------------------------------------------------------
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which
  // entries are live, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven in a combinational block gets a default first so
  // no path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      // A single-word frame (first word carries cmplt) closes immediately.
      IDLE:    if (push) state_next = frame_end ? DRAIN : RECV;
      RECV:    if (frame_end) state_next = DRAIN;
      DRAIN:   if (empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_start  = (state == IDLE) && push;
    frame_finish = (state == DRAIN) && empty;
  end

  // ---------------------------------------------------------------------------
  // Word counter and completion report
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (frame_start) begin
      cnt <= CNT_WIDTH'(1);
    end else if (push && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done  <= 1'b0;
      frame_words <= '0;
    end else begin
      frame_done <= frame_finish;
      if (frame_finish) frame_words <= cnt;
    end
  end

`ifdef SINK_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_acc   <= '0;
      frame_csum <= '0;
    end else begin
      if (frame_start) csum_acc <= push_data;
      else if (push)   csum_acc <= csum_acc ^ push_data;
      if (frame_finish) frame_csum <= csum_acc;
    end
  end
`endif

endmodule : bmp_sink_chan

// File: rtl/bmp_master_sink.sv
// -----------------------------------------------------------------------------
// bmp_master_sink
// Consumer of the accelerator master port. Demultiplexes tagged words into two
// per-slave channels, tracks frames per channel and reports completion once a
// channel's FIFO has drained.
//
// Optional feature macro: SINK_CHECKSUM_EN (adds frame0_csum / frame1_csum).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mstr0_data_valid[1:0]       source tag (01 slave0, 10 slave1, 00 idle, 11 bad)
//   mstr0_data                  word
//   mstr0_cmplt                 end-of-frame for the current source
//   mstr0_ready                 sink accepts a word this cycle
//   out{0,1}_data/valid/ready   per-channel output streams
//   frame{0,1}_done             completion pulse (frame closed and drained)
//   frame{0,1}_words            word count of last completed frame
//   frame{0,1}_csum             XOR of last completed frame (SINK_CHECKSUM_EN)
//   err_tag                     sticky: illegal tag seen while ready
// -----------------------------------------------------------------------------
module bmp_master_sink
  import bmp_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mstr0_data_valid,
  input  logic [DATA_WIDTH-1:0] mstr0_data,
  input  logic                  mstr0_cmplt,
  output logic                  mstr0_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic                  frame0_done,
  output logic [CNT_WIDTH-1:0]  frame0_words,
  output logic                  frame1_done,
  output logic [CNT_WIDTH-1:0]  frame1_words,
`ifdef SINK_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] frame0_csum,
  output logic [DATA_WIDTH-1:0] frame1_csum,
`endif
  output logic                  err_tag
);

  logic        alive;
  logic        full0, full1;
  chan_state_e state0, state1;
  logic        push0, push1;
  logic        end0, end1;
  logic        tag_bad;
  logic [1:0]  last_src;

  // Holds ready low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // A drain on either channel stalls both so frame boundaries stay ordered.
  assign mstr0_ready = alive && !full0 && !full1 &&
                       (state0 != DRAIN) && (state1 != DRAIN);

  assign push0   = mstr0_ready && (mstr0_data_valid == SRC_SLV0);
  assign push1   = mstr0_ready && (mstr0_data_valid == SRC_SLV1);
  assign tag_bad = mstr0_ready && (mstr0_data_valid == SRC_BAD);

  // cmplt belongs to the word arriving with it, or on an idle cycle to the
  // most recent source. last_src of 00 (nothing since reset) matches neither.
  assign end0 = mstr0_cmplt &&
                (push0 || ((mstr0_data_valid == SRC_IDLE) && (last_src == SRC_SLV0)));
  assign end1 = mstr0_cmplt &&
                (push1 || ((mstr0_data_valid == SRC_IDLE) && (last_src == SRC_SLV1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_src <= SRC_IDLE;
      err_tag  <= 1'b0;
    end else begin
      if (push0 || push1) last_src <= mstr0_data_valid;
      if (tag_bad)        err_tag  <= 1'b1;
    end
  end

  bmp_sink_chan #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_chan0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push0),
    .push_data   (mstr0_data),
    .frame_end   (end0),
    .full        (full0),
    .state       (state0),
    .out_data    (out0_data),
    .out_valid   (out0_valid),
    .out_ready   (out0_ready),
    .frame_done  (frame0_done),
    .frame_words (frame0_words)
`ifdef SINK_CHECKSUM_EN
    ,
    .frame_csum  (frame0_csum)
`endif
  );

  bmp_sink_chan #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_chan1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push1),
    .push_data   (mstr0_data),
    .frame_end   (end1),
    .full        (full1),
    .state       (state1),
    .out_data    (out1_data),
    .out_valid   (out1_valid),
    .out_ready   (out1_ready),
    .frame_done  (frame1_done),
    .frame_words (frame1_words)
`ifdef SINK_CHECKSUM_EN
    ,
    .frame_csum  (frame1_csum)
`endif
  );

endmodule : bmp_master_sink

// File: tb/tb_bmp_master_sink.sv
// -----------------------------------------------------------------------------
// tb_bmp_master_sink
// Directed scenarios plus randomized traffic. A queue-based model of the sink
// predicts every output; a compare process checks it each falling edge.
// -----------------------------------------------------------------------------
module tb_bmp_master_sink;

  localparam int DW = 32;
  localparam int D  = 16;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mstr0_data_valid = 2'b00;
  logic [DW-1:0] mstr0_data = '0;
  logic          mstr0_cmplt = 1'b0;
  logic          mstr0_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic          out0_valid, out1_valid;
  logic          out0_ready = 1'b0;
  logic          out1_ready = 1'b0;
  logic          frame0_done, frame1_done;
  logic [CW-1:0] frame0_words, frame1_words;
  logic          err_tag;
`ifdef SINK_CHECKSUM_EN
  logic [DW-1:0] frame0_csum, frame1_csum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bmp_master_sink #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mstr0_data_valid (mstr0_data_valid),
    .mstr0_data       (mstr0_data),
    .mstr0_cmplt      (mstr0_cmplt),
    .mstr0_ready      (mstr0_ready),
    .out0_data        (out0_data),
    .out0_valid       (out0_valid),
    .out0_ready       (out0_ready),
    .out1_data        (out1_data),
    .out1_valid       (out1_valid),
    .out1_ready       (out1_ready),
    .frame0_done      (frame0_done),
    .frame0_words     (frame0_words),
    .frame1_done      (frame1_done),
    .frame1_words     (frame1_words),
`ifdef SINK_CHECKSUM_EN
    .frame0_csum      (frame0_csum),
    .frame1_csum      (frame1_csum),
`endif
    .err_tag          (err_tag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue per channel plus frame bookkeeping.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mq [2][$];
  bit            m_alive;
  bit            m_err;
  bit [1:0]      m_last;
  bit            m_open    [2];   // frame has words and no end marker yet
  bit            m_closing [2];   // end marker seen, waiting for queue to empty
  int unsigned   m_cnt     [2];
  bit [DW-1:0]   m_acc     [2];
  bit            m_done    [2];
  bit [CW-1:0]   m_words   [2];
  bit [DW-1:0]   m_csum    [2];

  function automatic bit model_ready();
    return m_alive && (mq[0].size() < D) && (mq[1].size() < D) &&
           !m_closing[0] && !m_closing[1];
  endfunction

  initial begin
    bit rdy;
    int wch;
    bit fin  [2];
    bit endf [2];
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq[0].delete();
        mq[1].delete();
        m_alive = 0;
        m_err   = 0;
        m_last  = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
          m_open[ch] = 0; m_closing[ch] = 0; m_cnt[ch] = 0; m_acc[ch] = '0;
          m_done[ch] = 0; m_words[ch] = '0; m_csum[ch] = '0;
        end
      end else begin
        rdy = model_ready();
        wch = -1;
        if (rdy && mstr0_data_valid == 2'b01) wch = 0;
        else if (rdy && mstr0_data_valid == 2'b10) wch = 1;
        for (int ch = 0; ch < 2; ch++) begin
          fin[ch]  = m_closing[ch] && (mq[ch].size() == 0);
          endf[ch] = mstr0_cmplt &&
                     ((wch == ch) ||
                      (mstr0_data_valid == 2'b00 && int'(m_last) == ch + 1));
        end
        if (out0_ready && mq[0].size() > 0) void'(mq[0].pop_front());
        if (out1_ready && mq[1].size() > 0) void'(mq[1].pop_front());
        for (int ch = 0; ch < 2; ch++) begin
          m_done[ch] = fin[ch];
          if (fin[ch]) begin
            m_words[ch]   = CW'(m_cnt[ch]);
            m_csum[ch]    = m_acc[ch];
            m_closing[ch] = 0;
          end
        end
        if (wch >= 0) begin
          mq[wch].push_back(mstr0_data);
          if (!m_open[wch]) begin
            m_open[wch] = 1;
            m_cnt[wch]  = 1;
            m_acc[wch]  = mstr0_data;
          end else begin
            if (m_cnt[wch] < (32'd1 << CW) - 1) m_cnt[wch]++;
            m_acc[wch] = m_acc[wch] ^ mstr0_data;
          end
          m_last = mstr0_data_valid;
        end
        for (int ch = 0; ch < 2; ch++)
          if (endf[ch] && m_open[ch]) begin
            m_open[ch]    = 0;
            m_closing[ch] = 1;
          end
        if (rdy && mstr0_data_valid == 2'b11) m_err = 1;
        m_alive = 1;
      end
    end
  end

  // Compare process: outputs are registered, so the falling edge is stable.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ready", mstr0_ready, model_ready());
        check("out0_valid", out0_valid, mq[0].size() > 0);
        if (mq[0].size() > 0) check("out0_data", out0_data, mq[0][0]);
        check("out1_valid", out1_valid, mq[1].size() > 0);
        if (mq[1].size() > 0) check("out1_data", out1_data, mq[1][0]);
        check("frame0_done", frame0_done, m_done[0]);
        check("frame1_done", frame1_done, m_done[1]);
        check("frame0_words", frame0_words, m_words[0]);
        check("frame1_words", frame1_words, m_words[1]);
        check("err_tag", err_tag, m_err);
`ifdef SINK_CHECKSUM_EN
        check("frame0_csum", frame0_csum, m_csum[0]);
        check("frame1_csum", frame1_csum, m_csum[1]);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all return on a falling edge with the port idle)
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    mstr0_data_valid = 2'b00;
    mstr0_cmplt      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    idle_inputs();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #1 check("ready_in_reset", mstr0_ready, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] tag, input logic [DW-1:0] d, input bit c);
    int n = 0;
    while (!mstr0_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mstr0_ready) check("send_wait_ready", mstr0_ready, 1'b1);
    mstr0_data_valid = tag;
    mstr0_data       = d;
    mstr0_cmplt      = c;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_done(input int ch, output bit got);
    got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = (ch == 0) ? frame0_done : frame1_done;
    end
    check("done_seen", got, 1'b1);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (frame0_done || frame1_done) pulses++;
    end
  endtask

  // Global bound on simulated time.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int pulses;
    int p;
    int r;

    // ---- reset release ----
    repeat (3) @(negedge clk);
    check("ready_held_reset", mstr0_ready, 1'b0);
    check("valid0_reset", out0_valid, 1'b0);
    check("err_reset", err_tag, 1'b0);
    #2 rst_n = 1'b1;
    #1 check("ready_before_edge", mstr0_ready, 1'b0);
    @(negedge clk);
    check("ready_after_edge", mstr0_ready, 1'b1);
    send(2'b01, 32'hA5A5_0001, 1'b0);
    check("first_valid0", out0_valid, 1'b1);
    check("first_data0", out0_data, 32'hA5A5_0001);
    check("first_valid1", out1_valid, 1'b0);
    check("model_first_head", mq[0][0], 32'hA5A5_0001);

    // ---- 8-word frame on channel 1 ----
    do_reset();
    for (int i = 0; i < 8; i++) send(2'b10, 32'h1000 + i, i == 7);
    check("ready_drain1", mstr0_ready, 1'b0);
    check("valid1_held", out1_valid, 1'b1);
    out1_ready = 1'b1;
    wait_done(1, got);
    check("frame1_words_8", frame1_words, 8);
    check("model_words1_8", m_words[1], 8);
    check("frame0_quiet", frame0_done, 1'b0);
    count_pulses(10, pulses);
    check("single_pulse", pulses, 0);
    check("ready_after_frame", mstr0_ready, 1'b1);
    out1_ready = 1'b0;

    // ---- fill channel 0, pop once, wrap, drain in order ----
    do_reset();
    for (int i = 0; i < 16; i++) send(2'b01, 32'hC000_0000 + i, 1'b0);
    check("ready_full", mstr0_ready, 1'b0);
    check("model_depth", mq[0].size(), 16);
    out0_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0;
    check("ready_after_pop", mstr0_ready, 1'b1);
    send(2'b01, 32'hC000_0010, 1'b0);
    check("ready_full_again", mstr0_ready, 1'b0);
    out0_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("wrap_order", out0_data, 32'hC000_0000 + i);
      @(negedge clk);
    end
    out0_ready = 1'b0;
    check("drained0", out0_valid, 1'b0);

    // ---- interleaved sources, idle-cycle cmplt goes to last source ----
    do_reset();
    send(2'b01, 32'h11, 1'b0);
    send(2'b10, 32'h21, 1'b0);
    send(2'b01, 32'h12, 1'b0);
    send(2'b10, 32'h22, 1'b0);
    send(2'b00, 32'h0, 1'b1);
    check("ready_ch1_drain", mstr0_ready, 1'b0);
    out1_ready = 1'b1;
    wait_done(1, got);
    check("interleave_words1", frame1_words, 2);
    check("interleave_no_done0", frame0_done, 1'b0);
    check("interleave_ch0_kept", out0_valid, 1'b1);
    out1_ready = 1'b0;
    // Closing channel 0 with one more word shows its count was still 2.
    out0_ready = 1'b1;
    send(2'b01, 32'h13, 1'b1);
    wait_done(0, got);
    check("interleave_words0", frame0_words, 3);
    out0_ready = 1'b0;

    // ---- illegal tag, then asynchronous reset mid-frame ----
    send(2'b11, 32'hDEAD, 1'b0);
    check("err_set", err_tag, 1'b1);
    check("bad_no_write0", out0_valid, 1'b0);
    check("bad_no_write1", out1_valid, 1'b0);
    repeat (5) @(negedge clk);
    check("err_sticky", err_tag, 1'b1);
    send(2'b01, 32'h1, 1'b0);
    send(2'b01, 32'h2, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_err", err_tag, 1'b0);
    check("midrst_valid0", out0_valid, 1'b0);
    check("midrst_ready", mstr0_ready, 1'b0);
    check("midrst_words0", frame0_words, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out0_ready = 1'b1;
    count_pulses(10, pulses);
    check("midrst_no_done", pulses, 0);
    out0_ready = 1'b0;

`ifdef SINK_CHECKSUM_EN
    // ---- checksum of a small frame ----
    do_reset();
    out0_ready = 1'b1;
    send(2'b01, 32'h0F, 1'b0);
    send(2'b01, 32'hF0, 1'b0);
    send(2'b01, 32'hFF, 1'b1);
    wait_done(0, got);
    check("csum_zero", frame0_csum, 32'h0);
    check("csum_words", frame0_words, 3);
    check("model_csum_zero", m_csum[0], 32'h0);
    out0_ready = 1'b0;
`endif

    // ---- randomized traffic ----
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 99);
      mstr0_data_valid = (r < 40) ? 2'b01 : (r < 80) ? 2'b10 : (r < 97) ? 2'b00 : 2'b11;
      mstr0_data       = $urandom;
      mstr0_cmplt      = ($urandom_range(0, 11) == 0);
      p = ((cyc / 300) % 2 == 1) ? 20 : 85;
      out0_ready = ($urandom_range(0, 99) < p);
      out1_ready = ($urandom_range(0, 99) < p);
      @(negedge clk);
    end
    idle_inputs();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bmp_master_sink

// File: doc/bmp_master_sink.md
Name: bmp_master_sink

Overview:
- Downstream consumer of the image processing accelerator's master port (mstr0_*).
- Accepts processed pixel words and demultiplexes them by source slave into two per-channel FIFOs.
- Counts words per frame, detects end-of-frame from mstr0_cmplt, and reports frame completion once the channel FIFO has drained.
- Feeds two independent ready/valid output streams, one per originating slave.

Parameters:
DATA_WIDTH, 32, width of pixel data word.
FIFO_DEPTH, 16, entries per channel FIFO; power of two, minimum 4.
CNT_WIDTH, 24, width of per-frame word counters.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
mstr0_data_valid  input  2  source tag: 2'b01 = word from slave 0, 2'b10 = from slave 1, 2'b00 = idle, 2'b11 = illegal.
mstr0_data  input  DATA_WIDTH  processed word.
mstr0_cmplt  input  1  end-of-frame marker for the current source.
mstr0_ready  output  1  sink can accept a word this cycle.
out0_data  output  DATA_WIDTH  channel 0 FIFO head.
out0_valid  output  1  channel 0 head valid.
out0_ready  input  1  channel 0 consumer accepts.
out1_data / out1_valid / out1_ready  same as channel 0, for channel 1.
frame0_done  output  1  one-cycle pulse: channel 0 frame complete and drained.
frame0_words  output  CNT_WIDTH  word count of last completed channel-0 frame.
frame1_done / frame1_words  same as channel 0, for channel 1.
err_tag  output  1  sticky: 2'b11 tag seen while mstr0_ready was high.

Behaviour:
- Reset (rst_n low, async): FIFOs empty; all out*_valid, frame*_done, err_tag = 0; frame*_words = 0; channel states = IDLE; last_src cleared. An alive flop resets to 0, so mstr0_ready = 0 during reset; mstr0_ready rises in the first cycle after the first clock edge following deassertion.
- mstr0_ready = alive & !full0 & !full1 & (state0 != DRAIN) & (state1 != DRAIN). Combinational from registered state.
- A DRAIN on one channel deliberately stalls both channels.
- Transfer: a word is accepted when mstr0_ready is high and the tag is 01 or 10. It is written to the tagged FIFO, and last_src is set to the tag.
- Tag 11: the word is dropped and err_tag is set. Tag 00: no write.
- Latency: a word accepted at edge N is visible on outX_valid/outX_data after edge N. No combinational path from mstr0_* to out*.
- FIFO: outX_data = head entry. Pop on outX_valid & outX_ready. Simultaneous push and pop on the same channel is legal at any fill level except a push while full, which cannot occur because ready is low. Pointers carry an extra wrap bit; full/empty are derived from them.
- Per-channel FSM:
  - IDLE -> RECV on the first accepted word; the counter loads 1.
  - RECV: the counter increments per accepted word and saturates at all-ones.
  - RECV -> DRAIN when mstr0_cmplt is high and the frame's last word is being accepted on this channel in the same cycle, or when cmplt is high with tag 00 and last_src = this channel. That word is counted.
  - DRAIN -> IDLE when the FIFO is empty. In that cycle: frameX_done pulses and frameX_words is loaded with the counter.
  - cmplt when last_src is clear (no word yet since reset), or with tag 11: ignored.
- frameX_words holds its value until the next completion or reset.
- Reset mid-frame: all contents discarded, no done pulse.

Optional Feature:
- Macro SINK_CHECKSUM_EN.
- When defined: adds outputs frame0_csum and frame1_csum, each DATA_WIDTH wide. Each is the XOR of all words accepted in that channel's frame, loaded alongside frameX_words on the done pulse, and reset to 0.
- When undefined: these ports and the accumulator logic are absent. All other behaviour is identical.

Decomposition:
- Package bmp_sink_pkg holds:
  - SRC_SLV0 = 2'b01, SRC_SLV1 = 2'b10, SRC_BAD = 2'b11.
  - Channel state enum: IDLE, RECV, DRAIN.
- Sub-module bmp_sink_chan contains one FIFO, the FSM, the counter and, when SINK_CHECKSUM_EN is defined, the checksum. It exports full, state, out and frame signals.
- The top level instantiates two bmp_sink_chan and holds the tag decode, last_src, ready and err_tag logic.

Test Plan:
- Reset release: mstr0_ready = 0 while rst_n is low and goes to 1 one cycle after the first clock edge. Then push tag 01 with data 0xA5A5_0001 -> out0_valid = 1 next cycle with that data; out1_valid stays 0.
- Frame: 8 words on tag 10 with cmplt on the 8th, out1_ready held low -> mstr0_ready drops in DRAIN. Raise out1_ready -> 8 pops, then frame1_done pulses once with frame1_words = 8.
- Full: 16 words on tag 01 with out0_ready = 0 -> mstr0_ready = 0 after the 16th word. A single pop re-asserts ready the next cycle. Order is preserved across the pointer wrap.
- Interleave: words 01,10,01,10, then cmplt with tag 00 -> applies to channel 1 only. Channel 0 stays in RECV with its count at 2.
- Tag 11 with data 0xDEAD -> no FIFO write; err_tag = 1 and stays set. Async reset mid-frame clears err_tag, FIFOs and counters; no done pulse.
- Checksum (SINK_CHECKSUM_EN defined): a channel-0 frame of 0x0F, 0xF0, 0xFF -> frame0_csum = 0x00 on the done pulse.
